// File: rtl/qual_ff_clkdiv.sv
// Qualified WIDTH-bit capture register with parity, plus a programmable
// clock-enable divider whose ratio is reloaded from a shadow at period wrap.
module qual_ff_clkdiv #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NQUAL       = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DIV_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             RESB,
  input  logic [WIDTH-1:0] d,
  input  logic [NQUAL-1:0] qual,
  input  logic             ce,
  input  logic             sync_clr,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_load,
  output logic [WIDTH-1:0] q,
  output logic             q_par,
  output logic             div_tick,
  output logic             div_clk,
  output logic             div_pending,
  output logic [DIV_W-1:0] ratio_act
);

  localparam logic [DIV_W-1:0] RATIO_RST = DIV_W'(DIV_DEFAULT);

  logic [WIDTH-1:0] q_q, q_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             dclk_q, dclk_d;
  logic             wrap;

  always_comb begin
    q_d = q_q;
    if (sync_clr) begin
      q_d = '0;
    end else if (ce) begin
      if (&qual) begin
        q_d = d;
      end else if (MODE == 0) begin
        q_d = '0;
      end
    end
  end

  // Shadow always mirrors ratio_act while nothing is pending, so the wrap can
  // take the shadow unconditionally; a load on the wrap cycle bypasses it.
  always_comb begin
    wrap     = div_en && (cnt_q == ratio_q);
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    dclk_d   = dclk_q;
    if (div_load) begin
      shadow_d = div_ratio;
    end
    if (wrap) begin
      cnt_d   = '0;
      tick_d  = 1'b1;
      dclk_d  = ~dclk_q;
      ratio_d = div_load ? div_ratio : shadow_q;
      pend_d  = 1'b0;
    end else begin
      if (div_en) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (div_load) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RESB) begin
    if (!RESB) begin
      q_q      <= '0;
      cnt_q    <= '0;
      ratio_q  <= RATIO_RST;
      shadow_q <= RATIO_RST;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      dclk_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      dclk_q   <= dclk_d;
    end
  end

  assign q           = q_q;
  assign q_par       = ^q_q;
  assign div_tick    = tick_q;
  assign div_clk     = dclk_q;
  assign div_pending = pend_q;
  assign ratio_act   = ratio_q;

endmodule

// File: tb/tb_qual_ff_clkdiv.sv
// Bench for qual_ff_clkdiv: MODE0 and MODE1 instances share stimulus and are
// compared every cycle against a period-position reference model.
module tb_qual_ff_clkdiv;

  logic       clk = 1'b0;
  logic       RESB;
  logic [7:0] d;
  logic [3:0] qual;
  logic       ce, sync_clr, div_en, div_load;
  logic [3:0] div_ratio;

  logic [7:0] q0, q1;
  logic       par0, par1, tick0, tick1, dclk0, dclk1, pend0, pend1;
  logic [3:0] act0, act1;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: pos = enabled cycles completed in the current period.
  logic [7:0] m_q0, m_q1;
  int         m_pos, m_act, m_shadow;
  bit         m_pend, m_tick, m_dclk;

  always #5 clk = ~clk;

  qual_ff_clkdiv #(.WIDTH(8), .NQUAL(4), .MODE(0), .DIV_W(4), .DIV_DEFAULT(1)) dut0 (
    .clk(clk), .RESB(RESB), .d(d), .qual(qual), .ce(ce), .sync_clr(sync_clr),
    .div_en(div_en), .div_ratio(div_ratio), .div_load(div_load),
    .q(q0), .q_par(par0), .div_tick(tick0), .div_clk(dclk0),
    .div_pending(pend0), .ratio_act(act0));

  qual_ff_clkdiv #(.WIDTH(8), .NQUAL(4), .MODE(1), .DIV_W(4), .DIV_DEFAULT(1)) dut1 (
    .clk(clk), .RESB(RESB), .d(d), .qual(qual), .ce(ce), .sync_clr(sync_clr),
    .div_en(div_en), .div_ratio(div_ratio), .div_load(div_load),
    .q(q1), .q_par(par1), .div_tick(tick1), .div_clk(dclk1),
    .div_pending(pend1), .ratio_act(act1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q0 = '0; m_q1 = '0;
    m_pos = 0; m_act = 1; m_shadow = 1;
    m_pend = 0; m_tick = 0; m_dclk = 0;
  endtask

  task automatic model_edge();
    if (sync_clr) begin
      m_q0 = '0; m_q1 = '0;
    end else if (ce) begin
      if (qual == 4'hF) begin
        m_q0 = d; m_q1 = d;
      end else begin
        m_q0 = '0;
      end
    end
    m_tick = 0;
    if (div_en && m_pos == m_act) begin
      m_tick = 1;
      m_dclk = !m_dclk;
      m_pos  = 0;
      m_act  = div_load ? int'(div_ratio) : (m_pend ? m_shadow : m_act);
      m_pend = 0;
      if (div_load) m_shadow = div_ratio;
    end else begin
      if (div_en) m_pos = m_pos + 1;
      if (div_load) begin
        m_shadow = div_ratio;
        m_pend   = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("q_mode0",  32'(q0), 32'(m_q0));
    chk("q_mode1",  32'(q1), 32'(m_q1));
    chk("par_mode0", 32'(par0), 32'(^m_q0));
    chk("par_mode1", 32'(par1), 32'(^m_q1));
    chk("div_tick", 32'(tick0), 32'(m_tick));
    chk("div_clk",  32'(dclk0), 32'(m_dclk));
    chk("div_pending", 32'(pend0), 32'(m_pend));
    chk("ratio_act", 32'(act0), 32'(m_act));
    chk("div_tick_m1", 32'(tick1), 32'(m_tick));
    chk("div_clk_m1",  32'(dclk1), 32'(m_dclk));
    chk("ratio_act_m1", 32'(act1), 32'(m_act));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    div_load = 1'b0;
  endtask

  initial begin
    RESB = 1'b0; d = '0; qual = '0; ce = 0; sync_clr = 0;
    div_en = 0; div_ratio = '0; div_load = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    RESB = 1'b1;

    // First tick two enabled cycles after release at the default ratio 1
    div_en = 1;
    cyc(); chk("rel_tick_c1", 32'(tick0), 32'd0);
    cyc(); chk("rel_tick_c2", 32'(tick0), 32'd1);
    div_en = 0;

    // Capture path
    ce = 1; qual = 4'hF; d = 8'h3C;
    cyc(); chk("cap_q", 32'(q0), 32'h3C); chk("cap_par", 32'(par0), 32'd0);
    qual = 4'hE;
    cyc(); chk("unq_m0", 32'(q0), 32'h00); chk("unq_m1", 32'(q1), 32'h3C);
    qual = 4'hF; sync_clr = 1;
    cyc(); chk("sclr_m0", 32'(q0), 32'h00); chk("sclr_m1", 32'(q1), 32'h00);
    sync_clr = 0; ce = 0;

    // Divide by 4: load R=3 while idle, then run
    div_ratio = 4'd3; div_load = 1;
    cyc(); chk("load_pend", 32'(pend0), 32'd1);
    div_en = 1;
    for (int i = 0; i < 24; i++) cyc();

    // Mid-period change to R=0 at cnt=1
    for (int i = 0; i < 8 && m_pos != 1; i++) cyc();
    div_ratio = 4'd0; div_load = 1;
    cyc(); chk("mid_pend", 32'(pend0), 32'd1);
    for (int i = 0; i < 8; i++) cyc();
    chk("r0_tick", 32'(tick0), 32'd1);

    // Double load within one period: 5 then 2, only 2 applies
    div_ratio = 4'd3; div_load = 1; cyc();
    for (int i = 0; i < 8 && m_pos != 0; i++) cyc();
    cyc();
    div_ratio = 4'd5; div_load = 1; cyc();
    div_ratio = 4'd2; div_load = 1; cyc();
    for (int i = 0; i < 12; i++) cyc();
    chk("dbl_ratio", 32'(act0), 32'd2);

    // Load coinciding with the wrap edge applies at once
    for (int i = 0; i < 8 && m_pos != m_act; i++) cyc();
    div_ratio = 4'd6; div_load = 1;
    cyc(); chk("coin_pend", 32'(pend0), 32'd0); chk("coin_ratio", 32'(act0), 32'd6);
    for (int i = 0; i < 10; i++) cyc();

    // Enable gating at cnt=2
    for (int i = 0; i < 10 && m_pos != 2; i++) cyc();
    div_en = 0;
    for (int i = 0; i < 5; i++) cyc();
    div_en = 1;
    for (int i = 0; i < 12; i++) cyc();

    // Asynchronous reset mid-operation with q=A5
    ce = 1; qual = 4'hF; d = 8'hA5; cyc(); ce = 0;
    #2 RESB = 1'b0;
    #1 model_reset();
    check_all();
    chk("ares_q", 32'(q0), 32'h00);
    @(negedge clk);
    check_all();
    RESB = 1'b1;
    cyc(); cyc(); chk("ares_tick", 32'(tick0), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      d         = 8'($urandom);
      qual      = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      ce        = ($urandom_range(0, 3) != 0);
      sync_clr  = ($urandom_range(0, 15) == 0);
      div_en    = ($urandom_range(0, 3) != 0);
      div_ratio = 4'($urandom_range(0, 6));
      div_load  = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/qual_ff_clkdiv.md
Name: qual_ff_clkdiv

Overview:
Parametrised successor to the single-bit qualified capture flop. It provides a WIDTH-bit data register that captures only when every qualifier input is high, plus a parity output. It also contains a programmable clock-enable divider that generates divided tick/clock outputs; the divider ratio is reloaded glitch-free. It sits at the clock/reset-qualification boundary and feeds downstream clock-enable and status logic.

Parameters:
WIDTH, 8, data register width in bits (>=1)
NQUAL, 4, number of AND-combined capture qualifiers (>=1)
MODE, 0, 0 = unqualified capture loads zero; 1 = unqualified capture holds q
DIV_W, 4, width of divider ratio and counter
DIV_DEFAULT, 1, divider ratio applied out of reset (must fit DIV_W)

Ports:
clk  input  1  single clock, rising edge
RESB  input  1  asynchronous active-low reset
d  input  WIDTH  capture data
qual  input  NQUAL  capture qualifiers; all must be 1 for a qualified capture
ce  input  1  capture enable
sync_clr  input  1  synchronous clear of q
div_en  input  1  divider run enable
div_ratio  input  DIV_W  requested ratio R; divide-by (R+1)
div_load  input  1  one-cycle strobe: latch div_ratio into shadow
q  output  WIDTH  registered data
q_par  output  1  combinational XOR-reduction of q
div_tick  output  1  registered one-cycle pulse every (R+1) enabled cycles
div_clk  output  1  registered divided clock, toggles on each div_tick, period 2(R+1)
div_pending  output  1  shadow ratio loaded but not yet applied
ratio_act  output  DIV_W  ratio currently in effect

Behaviour:
- Reset (RESB=0, asynchronous, any time): q=0, div_tick=0, div_clk=0, cnt=0, div_pending=0, ratio_act=DIV_DEFAULT, shadow=DIV_DEFAULT. Release is synchronous to the next clk edge; the first count occurs on the first edge after RESB=1.
- Capture priority per edge: sync_clr=1 -> q<=0. Else ce=0 -> hold. Else &qual=1 -> q<=d. Else MODE0 -> q<=0; MODE1 -> hold.
- q_par = ^q, zero latency relative to q.
- Divider counter cnt runs 0..ratio_act, incrementing only when div_en=1. When div_en=0: cnt holds, div_tick=0, div_clk holds.
- Wrap: when div_en=1 and cnt==ratio_act: cnt<=0, div_tick<=1 on the next cycle, div_clk toggles in the same register update. Otherwise div_tick<=0.
- R=0: div_tick is high every enabled cycle and div_clk toggles every enabled cycle (half clk rate).
- div_load=1: shadow<=div_ratio, div_pending<=1. A second load while pending overwrites the shadow; only the last value is applied.
- Apply: at the next wrap (div_en=1, cnt==ratio_act): ratio_act<=shadow, div_pending<=0. The current period always completes at the old ratio, so no truncated or stretched period occurs.
- div_load coincident with a wrap: the new div_ratio is written to the shadow and applied at that same wrap; div_pending stays 0.
- Loading a value equal to ratio_act still sets div_pending and clears it at the wrap; there is no output effect.
- Capture path and divider are independent; sync_clr does not affect the divider.
- All outputs except q_par are registered.
- Counter width is DIV_W and the counter never exceeds ratio_act, so there is no overflow.

Test Plan:
- Reset: RESB=0 mid-operation with q=8'hA5 and cnt=3 -> q=0, div_clk=0, div_tick=0 and ratio_act=1 immediately (asynchronous); after release, first div_tick appears 2 enabled cycles later.
- Qualified capture: ce=1, qual=4'hF, d=8'h3C -> q=8'h3C, q_par=0 next cycle. Then qual=4'hE: MODE0 -> q=8'h00; MODE1 -> q stays 8'h3C. sync_clr=1 with ce=1 and qual=F -> q=0.
- Divide: div_ratio=3 loaded at reset idle, div_en=1 -> after the first wrap, div_tick pulses every 4 cycles and div_clk period is 8 cycles at 50% duty.
- Ratio change mid-period: ratio_act=3, cnt=1, load R=0 -> div_pending=1; remaining period finishes at 4 cycles; then div_tick is high every cycle and div_pending=0.
- Double load and coincident load: load 5 then 2 within one period -> only 2 is applied. A load of 6 on the wrap cycle -> applied immediately and div_pending is never set.
- div_en gating: drop div_en for 5 cycles at cnt=2 -> cnt holds, no div_tick, div_clk frozen; counting resumes from 2 when div_en returns.
